// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low key matrix, debounces whole-matrix frames
// and reports one accepted press (codes 1-8) with a single-cycle strobe.
//
// Optional feature macro: KEYPAD_RELEASE_PULSE_EN (adds the key_release strobe).
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   col_in[3:0]    matrix columns, active-low, asynchronous to clk
//   row_out[3:0]   row drive, active-low, one row low at a time
//   key_code[3:0]  0 = no key, 1-8 = accepted note
//   keypad_enable  single-cycle press strobe
//   key_release    single-cycle release strobe (KEYPAD_RELEASE_PULSE_EN only)
module keypad_scan #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       keypad_enable
`ifdef KEYPAD_RELEASE_PULSE_EN
    ,
    output logic       key_release
`endif
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_KEY  = 2'd1,
        CLS_BAD  = 2'd2
    } cls_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    logic [3:0]        col_meta;
    logic [3:0]        col_sync;
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        row_sel;
    logic [15:0]       frame;
    logic              slot_end;
    logic              frame_done;

    logic [15:0]       frame_full;
    logic [4:0]        ones;
    logic [3:0]        hit_idx;
    cls_t              cls;
    logic [2:0]        cls_idx;

    cls_t              prev_cls;
    logic [2:0]        prev_idx;
    logic [3:0]        stable_cnt;
    logic [3:0]        stable_nxt;

    state_t            state;
    state_t            state_nxt;
    logic              press_acc;
    logic              release_acc;
    logic [3:0]        key_code_d;
    logic              keypad_enable_d;
`ifdef KEYPAD_RELEASE_PULSE_EN
    logic              key_release_d;
`endif

    // Two-flop synchronizer; idle value is "no column pulled low".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end
    end

    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign frame_done = slot_end && (row_sel == 2'd3);

    // Row scan: sample the driven row on its last slot clock, then advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            row_sel  <= 2'd0;
            row_out  <= 4'b1110;
            frame    <= '0;
        end else if (slot_end) begin
            slot_cnt                    <= '0;
            row_sel                     <= row_sel + 2'd1;
            row_out                     <= ~(4'b0001 << (row_sel + 2'd1));
            frame[{row_sel, 2'b00} +: 4] <= ~col_sync;
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Classify the frame being completed; row 3 comes straight from the sampler.
    always_comb begin
        frame_full        = frame;
        frame_full[15:12] = ~col_sync;
        ones              = 5'd0;
        hit_idx           = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_full[i]) begin
                ones    = ones + 5'd1;
                hit_idx = 4'(i);
            end
        end
        if (ones == 5'd0) begin
            cls = CLS_NONE;
        end else if ((ones == 5'd1) && !hit_idx[3]) begin
            cls = CLS_KEY;
        end else begin
            cls = CLS_BAD;
        end
        cls_idx = (cls == CLS_KEY) ? hit_idx[2:0] : 3'd0;
    end

    // Post-update stability count, saturating at DEBOUNCE_FRAMES.
    always_comb begin
        if ((cls == prev_cls) && (cls_idx == prev_idx)) begin
            stable_nxt = (stable_cnt >= DF) ? DF : (stable_cnt + 4'd1);
        end else begin
            stable_nxt = 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_cls   <= CLS_NONE;
            prev_idx   <= 3'd0;
            stable_cnt <= 4'd0;
        end else if (frame_done) begin
            prev_cls   <= cls;
            prev_idx   <= cls_idx;
            stable_cnt <= stable_nxt;
        end
    end

    assign press_acc   = frame_done && (state == ST_IDLE) && (cls == CLS_KEY)
                         && (stable_nxt == DF);
    assign release_acc = frame_done && (state == ST_HELD) && (cls == CLS_NONE)
                         && (stable_nxt == DF);

    // FSM state register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            key_code      <= 4'd0;
            keypad_enable <= 1'b0;
`ifdef KEYPAD_RELEASE_PULSE_EN
            key_release   <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            key_code      <= key_code_d;
            keypad_enable <= keypad_enable_d;
`ifdef KEYPAD_RELEASE_PULSE_EN
            key_release   <= key_release_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (press_acc)   state_nxt = ST_HELD;
            ST_HELD: if (release_acc) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic; key changes while held are deliberately ignored.
    always_comb begin
        key_code_d      = key_code;
        keypad_enable_d = 1'b0;
`ifdef KEYPAD_RELEASE_PULSE_EN
        key_release_d   = 1'b0;
`endif
        if (press_acc) begin
            key_code_d      = {1'b0, cls_idx} + 4'd1;
            keypad_enable_d = 1'b1;
        end else if (release_acc) begin
            key_code_d      = 4'd0;
`ifdef KEYPAD_RELEASE_PULSE_EN
            key_release_d   = 1'b1;
`endif
        end
    end

endmodule
